// File: rtl/rv_lsu.sv
// rv_lsu: load/store unit driving the data port of the shared I/D RAM.
// Accepts one request at a time and returns exactly one response per request.
// Loads extract and extend byte/halfword lanes. Sub-word stores do a
// read-modify-write. Misaligned or invalid-size requests are answered with an
// error and never touch memory.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_valid       request present
//   req_ready       idle and able to accept a request
//   req_we          1 = store, 0 = load
//   req_size        0 = byte, 1 = halfword, 2 = word, 3 = invalid
//   req_unsigned    load zero-extend (1) or sign-extend (0)
//   req_addr        byte address
//   req_wdata       store data (low byte/halfword for sub-word stores)
//   req_tag         opaque tag, echoed on rsp_tag
//   rsp_valid       one-cycle response pulse
//   rsp_data        load result, 0 for stores and errors
//   rsp_err         misaligned address or invalid size
//   rsp_tag         tag of the completed request
//   mem_en, mem_we  memory enable / write enable
//   mem_addr        word index {2'b0, addr[31:2]}
//   mem_din         memory write data
//   mem_dout        memory read data, valid the cycle after an enabled read
module rv_lsu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_BAD  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DATA,
        ST_MERGE,
        ST_RESP,
        ST_ERR
    } state_t;

    state_t state, state_n;

    // Latched request fields
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [1:0]            lane_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    // Next values of the registered outputs
    logic                  rsp_valid_n;
    logic                  rsp_err_n;
    logic [DATA_WIDTH-1:0] rsp_data_n;
    logic                  mem_en_n;
    logic                  mem_we_n;
    logic [DATA_WIDTH-1:0] mem_addr_n;
    logic [DATA_WIDTH-1:0] mem_din_n;
    logic                  accept;

    logic                  req_bad;
    logic [4:0]            lane_sh;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] merged;

    assign req_ready = (state == ST_IDLE) && !rst;

    // Alignment / size check on the incoming request
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            SZ_HALF: req_bad = req_addr[0];
            SZ_WORD: req_bad = (req_addr[1:0] != 2'b00);
            SZ_BAD:  req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    // Aligned halfwords have lane_q[0] = 0, so one shift serves all sizes.
    always_comb begin
        lane_sh   = {lane_q, 3'b000};
        shifted   = mem_dout >> lane_sh;
        load_ext  = shifted;
        case (size_q)
            SZ_BYTE: load_ext = uns_q ? DATA_WIDTH'(shifted[7:0])
                                      : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_ext = uns_q ? DATA_WIDTH'(shifted[15:0])
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
        lane_mask = ((size_q == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
        merged    = (mem_dout & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_data_n  = '0;
        mem_en_n    = 1'b0;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_din_n   = mem_din;
        accept      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_bad) begin
                        state_n     = ST_ERR;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                    end else begin
                        state_n    = ST_ISSUE;
                        mem_en_n   = 1'b1;
                        mem_addr_n = {2'b00, req_addr[DATA_WIDTH-1:2]};
                        if (req_we && (req_size == SZ_WORD)) begin
                            mem_we_n  = 1'b1;
                            mem_din_n = req_wdata;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (we_q && (size_q == SZ_WORD)) begin
                    state_n     = ST_RESP;
                    rsp_valid_n = 1'b1;
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!we_q) begin
                    state_n     = ST_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = load_ext;
                end else begin
                    state_n   = ST_MERGE;
                    mem_en_n  = 1'b1;
                    mem_we_n  = 1'b1;
                    mem_din_n = merged;
                end
            end
            ST_MERGE: begin
                state_n     = ST_RESP;
                rsp_valid_n = 1'b1;
            end
            ST_RESP: state_n = ST_IDLE;
            ST_ERR:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Output registers and request latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            lane_q    <= 2'b00;
            wdata_q   <= '0;
        end else begin
            rsp_valid <= rsp_valid_n;
            rsp_err   <= rsp_err_n;
            rsp_data  <= rsp_data_n;
            mem_en    <= mem_en_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_din   <= mem_din_n;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                lane_q  <= req_addr[1:0];
                wdata_q <= req_wdata;
                rsp_tag <= req_tag;
            end
        end
    end

endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: scoreboard bench for rv_lsu with a small behavioural RAM.
// Expected responses are queued at acceptance and compared when rsp_valid
// pulses; memory port activity is checked cycle by cycle after acceptance.
module tb_rv_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_tag;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [1:0]  rsp_tag;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    always #5 clk = ~clk;

    rv_lsu #(.DATA_WIDTH(32), .TAG_WIDTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_tag      (req_tag),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .rsp_tag      (rsp_tag),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Behavioural RAM: synchronous read, write on enabled write cycles
    logic [31:0] mem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        if (mem_en) begin
            if (mem_we) mem[mem_addr[5:0]] <= mem_din;
            else        mem_dout <= mem[mem_addr[5:0]];
        end
    end

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        pre_idx  = 6'(idx);
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [1:0]  tag;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Response monitor: pop and compare on every response pulse
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("spurious_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_data", rsp_data, mon_e.data);
                check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                check("rsp_tag", 32'(rsp_tag), 32'(mon_e.tag));
                check("rsp_latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
            end
        end
    end

    task automatic do_req(input string nm, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] tg, input logic [31:0] exp_data,
                          input logic exp_err, input logic [31:0] exp_din);
        int   n;
        int   lat;
        logic sub_st;
        logic exp_en;
        logic exp_we;
        exp_t e;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({nm, "_ready_timeout"}, 32'(req_ready), 32'd1);
            return;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_tag      = tg;
        @(posedge clk);
        #1;
        // Garbage request held while busy must be ignored
        req_we       = 1'(($urandom));
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_tag      = 2'($urandom);
        sub_st = we && (size != 2'd2);
        lat    = exp_err ? 1 : (!we ? 3 : (sub_st ? 4 : 2));
        e.data = exp_data;
        e.err  = exp_err;
        e.tag  = tg;
        e.acc  = cyc;
        e.lat  = lat;
        sb.push_back(e);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            exp_en = !exp_err && ((k == 1) || ((k == 3) && sub_st));
            exp_we = (k == 3) || (we && !sub_st);
            check({nm, "_mem_en"}, 32'(mem_en), 32'(exp_en));
            if (exp_en) begin
                check({nm, "_mem_we"}, 32'(mem_we), 32'(exp_we));
                check({nm, "_mem_addr"}, mem_addr, {2'b00, addr[31:2]});
                if (exp_we) check({nm, "_mem_din"}, mem_din, exp_din);
            end
            if (k == lat) req_valid = 1'b0;
        end
        @(negedge clk);
        check({nm, "_ready_after"}, 32'(req_ready), 32'd1);
        check({nm, "_rsp_seen"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_tag      = '0;

        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        preload(5, 32'h80FF_7F01);
        @(negedge clk);
        rst = 1'b0;

        // Loads from mem[5] = 0x80FF7F01
        do_req("ld_word",  1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 2'd1, 32'h80FF_7F01, 1'b0, 32'h0);
        do_req("ld_b17_s", 1'b0, 2'd0, 1'b0, 32'h17, 32'h0, 2'd2, 32'hFFFF_FF80, 1'b0, 32'h0);
        do_req("ld_b17_u", 1'b0, 2'd0, 1'b1, 32'h17, 32'h0, 2'd3, 32'h0000_0080, 1'b0, 32'h0);
        do_req("ld_h16_s", 1'b0, 2'd1, 1'b0, 32'h16, 32'h0, 2'd0, 32'hFFFF_80FF, 1'b0, 32'h0);
        do_req("ld_h16_u", 1'b0, 2'd1, 1'b1, 32'h16, 32'h0, 2'd1, 32'h0000_80FF, 1'b0, 32'h0);
        do_req("ld_b14_s", 1'b0, 2'd0, 1'b0, 32'h14, 32'h0, 2'd2, 32'h0000_0001, 1'b0, 32'h0);
        do_req("ld_h14_s", 1'b0, 2'd1, 1'b0, 32'h14, 32'h0, 2'd3, 32'h0000_7F01, 1'b0, 32'h0);

        // Reset in the DATA cycle of a load
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h14;
        req_tag   = 2'd2;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
        check("mid_rst_rsp_data", rsp_data, 32'd0);
        check("mid_rst_rsp_tag", 32'(rsp_tag), 32'd0);
        check("mid_rst_mem_en", 32'(mem_en), 32'd0);
        check("mid_rst_mem_we", 32'(mem_we), 32'd0);
        check("mid_rst_mem_addr", mem_addr, 32'd0);
        check("mid_rst_mem_din", mem_din, 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_req_ready", 32'(req_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_req("ld_after_rst", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 2'd3, 32'h80FF_7F01, 1'b0, 32'h0);

        // Sub-word stores into mem[5] = 0x11223344
        preload(5, 32'h1122_3344);
        do_req("st_b15", 1'b1, 2'd0, 1'b0, 32'h15, 32'hFFFF_FFAB, 2'd1, 32'h0, 1'b0, 32'h1122_AB44);
        check("mem5_after_sb", mem[5], 32'h1122_AB44);
        do_req("st_h16", 1'b1, 2'd1, 1'b0, 32'h16, 32'h1234_CAFE, 2'd2, 32'h0, 1'b0, 32'hCAFE_AB44);
        do_req("ld_mem5", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 2'd0, 32'hCAFE_AB44, 1'b0, 32'h0);

        // Word store and read-back
        do_req("st_w20", 1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, 2'd3, 32'h0, 1'b0, 32'hDEAD_BEEF);
        do_req("ld_w20", 1'b0, 2'd2, 1'b1, 32'h20, 32'h0, 2'd1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        do_req("ld_b23_u", 1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 2'd2, 32'h0000_00DE, 1'b0, 32'h0);

        // Errors
        do_req("err_h13", 1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 2'd1, 32'h0, 1'b1, 32'h0);
        do_req("err_w22", 1'b1, 2'd2, 1'b0, 32'h22, 32'h5555_5555, 2'd2, 32'h0, 1'b1, 32'h0);
        do_req("err_sz3", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 2'd3, 32'h0, 1'b1, 32'h0);
        check("mem8_after_err", mem[8], 32'hDEAD_BEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv_lsu.md
# rv_lsu

Load/store unit that drives the data port of the shared instruction/data RAM on behalf of the core pipeline. It accepts one request at a time and returns one response per request. It performs word-aligned memory accesses, byte/halfword extraction with sign or zero extension for loads, and read-modify-write for sub-word stores. It reports misaligned and invalid-size requests without touching memory.

## Interface
- DATA_WIDTH, 32, data and address width; fixed at 32 for this block.
- TAG_WIDTH, 2, width of the request tag (thread id), returned unchanged with the response.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  a request is present.
- req_ready  output  1  unit is idle and accepts a request; high only in IDLE with rst low.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is invalid.
- req_unsigned  input  1  for loads, 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low byte or low halfword is used for sub-word stores.
- req_tag  input  TAG_WIDTH  opaque tag.
- rsp_valid  output  1  one-cycle response pulse; there is no backpressure.
- rsp_data  output  32  load result; 0 for stores and errors.
- rsp_err  output  1  misaligned address or invalid size.
- rsp_tag  output  TAG_WIDTH  tag of the completed request.
- mem_en  output  1  memory access enable.
- mem_we  output  1  memory write enable; only meaningful when mem_en = 1.
- mem_addr  output  32  word index, equal to {2'b0, addr[31:2]}.
- mem_din  output  32  write data to memory.
- mem_dout  input  32  read data; valid in the cycle after an enabled read.

## Operation
- Handshake: a request is accepted when req_valid && req_ready. All request fields are latched on acceptance. Inputs are ignored while the unit is busy.
- Alignment rules: halfword requires addr[0] = 0. Word requires addr[1:0] = 0. req_size = 3 is always an error.
- Byte lanes are little-endian: lane k covers bits [8k+7:8k]. For a byte, k = addr[1:0]. For a halfword, the lower lane is addr[1]*2.
- State machine:
  - IDLE: req_ready = 1. On accept, go to ERR if the request is misaligned or invalid, otherwise to ISSUE.
  - ISSUE: mem_en = 1, mem_addr = word index. For a word store, mem_we = 1 and mem_din = wdata, then go to RESP. For a load or sub-word store, mem_we = 0, then go to DATA.
  - DATA: capture mem_dout into the data register. A load goes to RESP with the extracted lane(s), extended per req_unsigned. A sub-word store goes to MERGE.
  - MERGE: mem_en = 1, mem_we = 1, same mem_addr. mem_din = captured word with only the target lane(s) replaced by wdata[7:0] or wdata[15:0]. Then go to RESP.
  - RESP: rsp_valid = 1, rsp_err = 0, then go to IDLE.
  - ERR: rsp_valid = 1, rsp_err = 1, rsp_data = 0. No mem_en is asserted. Then go to IDLE.
- rsp_tag holds the latched tag whenever rsp_valid = 1.
- mem_en = 0 in IDLE, DATA, RESP and ERR. Memory outputs are registered or derived only from latched state, never from the req_* inputs.

## Timing
- Acceptance happens at the edge ending cycle 0. rsp_valid is high in the following cycle:
  - cycle 2 for a word store;
  - cycle 3 for a load;
  - cycle 4 for a sub-word store;
  - cycle 1 for an error.
- Back-to-back operation: req_ready returns high the cycle after rsp_valid. Minimum load throughput is one request per 4 cycles.
- Reset values: state = IDLE. rsp_valid, rsp_err, rsp_data, rsp_tag, mem_en, mem_we, mem_addr and mem_din are all 0. req_ready = 0 while rst is high.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and no response is produced. The memory write of a MERGE or word-store ISSUE cycle that is interrupted by reset is not guaranteed.
- Address wrap: mem_addr uses addr[31:2] only. Any bits beyond the RAM depth are truncated by the RAM, not by this block.

## Test plan
- Word load: preload mem[5] = 0x80FF7F01. Send a load, size 2, addr 0x14, tag 1. Required: mem_en pulses with addr 5 in cycle 1, then rsp_valid in cycle 3 with data 0x80FF7F01 and tag 1.
- Sub-word loads from the same word:
  - byte at 0x17, signed → 0xFFFFFF80;
  - byte at 0x17, unsigned → 0x00000080;
  - halfword at 0x16, signed → 0xFFFF80FF;
  - byte at 0x14, signed → 0x00000001.
- Byte store: mem[5] = 0x11223344. Store byte 0xAB (wdata 0xFFFFFFAB) at 0x15. Required:
  - cycle 1: read of mem_addr 5;
  - cycle 3: write of mem_din 0x1122AB44;
  - cycle 4: rsp_valid with data 0.
- Word store: store 0xDEADBEEF at 0x20. Required: a single write to addr 8 in cycle 1 and rsp_valid in cycle 2.
- Errors:
  - halfword at 0x13 → rsp_err = 1 in cycle 1, with mem_en never asserted;
  - word at 0x22 → rsp_err = 1;
  - req_size 3 at 0x0 → rsp_err = 1.
- Reset mid-load: assert rst in the DATA cycle. Required: all outputs 0 at once, no rsp_valid, and req_ready = 1 on the first cycle after rst falls. A new load then completes normally.
